// File: rtl/iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, signed fixup on completion.
// Optional DIV_EARLY_ZERO_EN: a zero divisor bypasses CALC and completes directly.
module iter_divider #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sign_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CntW = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Width-1:0]  rem_q, rem_d;
  logic [Width-1:0]  quo_q, quo_d;
  logic [Width-1:0]  dvs_q, dvs_d;
  logic [Width-1:0]  dvd_raw_q, dvd_raw_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              zero_q, zero_d;
  logic [Width-1:0]  quotient_q, quotient_d;
  logic [Width-1:0]  remainder_q, remainder_d;
  logic              div_zero_q, div_zero_d;

  logic              accept;
  logic [Width:0]    partial;
  logic [Width-1:0]  diff;
  logic              ge;
  logic [Width-1:0]  rem_nx, quo_nx;

  // Trial subtract: the remainder stays below the divisor, so W bits suffice after restore.
  always_comb begin
    partial = {rem_q, quo_q[Width-1]};
    ge      = partial >= {1'b0, dvs_q};
    diff    = partial[Width-1:0] - dvs_q;
    rem_nx  = ge ? diff : partial[Width-1:0];
    quo_nx  = {quo_q[Width-2:0], ge};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_raw_d   = dvd_raw_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    accept      = (state_q != CALC) && start_i && !flush_i;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d    = CALC;
          cnt_d      = '0;
          rem_d      = '0;
          quo_d      = (sign_i && dividend_i[Width-1]) ? -dividend_i : dividend_i;
          dvs_d      = (sign_i && divisor_i[Width-1])  ? -divisor_i  : divisor_i;
          dvd_raw_d  = dividend_i;
          qneg_d     = sign_i & (dividend_i[Width-1] ^ divisor_i[Width-1]);
          rneg_d     = sign_i & dividend_i[Width-1];
          zero_d     = (divisor_i == '0);
          div_zero_d = 1'b0;
`ifdef DIV_EARLY_ZERO_EN
          if (divisor_i == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend_i;
            div_zero_d  = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast && !flush_i) begin
          state_d     = DONE;
          cnt_d       = '0;
          quotient_d  = zero_q ? '1        : (qneg_q ? -quo_nx : quo_nx);
          remainder_d = zero_q ? dvd_raw_q : (rneg_q ? -rem_nx : rem_nx);
          div_zero_d  = zero_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything else; results from the aborted op are never published.
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_raw_q   <= dvd_raw_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy_o      = (state_q == CALC);
  assign valid_o     = (state_q == DONE);
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed-vector bench for iter_divider (Width=32) with immediate-assertion checks.
module tb_iter_divider;
  logic        clk_i = 1'b0;
  logic        rst_ni, start_i, sign_i, flush_i;
  logic [31:0] dividend_i, divisor_i;
  logic        busy_o, valid_o, div_zero_o;
  logic [31:0] quotient_o, remainder_o;

  int nvec = 0;
  int nerr = 0;
  int lat, bcnt, vcnt;

  iter_divider #(.Width(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .sign_i(sign_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .flush_i(flush_i),
    .busy_o(busy_o), .valid_o(valid_o), .quotient_o(quotient_o),
    .remainder_o(remainder_o), .div_zero_o(div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Raises start in the current cycle; returns cycles from start to valid and busy-cycle count.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int l, output int bc);
    sign_i = s; dividend_i = a; divisor_i = b; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    l = 1; bc = 0;
    while (!valid_o && l < 200) begin
      if (busy_o) bc++;
      tick();
      l++;
    end
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; sign_i = 1'b0; flush_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_q", quotient_o, 32'd0);
    chk("rst_r", remainder_o, 32'd0);
    chk("rst_dz", 32'(div_zero_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    do_op(1'b0, 32'd100, 32'd7, lat, bcnt);
    chk("u100_7_lat", 32'(lat), 32'd33);
    chk("u100_7_busy", 32'(bcnt), 32'd32);
    chk("u100_7_q", quotient_o, 32'd14);
    chk("u100_7_r", remainder_o, 32'd2);
    chk("u100_7_dz", 32'(div_zero_o), 32'd0);
    tick();
    chk("valid_pulse", 32'(valid_o), 32'd0);
    chk("hold_q", quotient_o, 32'd14);

    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk("s-7_2_q", quotient_o, 32'hFFFF_FFFD);
    chk("s-7_2_r", remainder_o, 32'hFFFF_FFFF);
    // Back-to-back: start raised in the DONE cycle must be accepted.
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    chk("s7_-2_lat", 32'(lat), 32'd33);
    chk("s7_-2_q", quotient_o, 32'hFFFF_FFFD);
    chk("s7_-2_r", remainder_o, 32'd1);

    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("smin_q", quotient_o, 32'h8000_0000);
    chk("smin_r", remainder_o, 32'd0);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("umin_q", quotient_o, 32'd0);
    chk("umin_r", remainder_o, 32'h8000_0000);

    do_op(1'b0, 32'h1234, 32'd0, lat, bcnt);
`ifdef DIV_EARLY_ZERO_EN
    chk("dz_lat", 32'(lat), 32'd1);
    chk("dz_busy", 32'(bcnt), 32'd0);
`else
    chk("dz_lat", 32'(lat), 32'd33);
    chk("dz_busy", 32'(bcnt), 32'd32);
`endif
    chk("dz_q", quotient_o, 32'hFFFF_FFFF);
    chk("dz_r", remainder_o, 32'h1234);
    chk("dz_flag", 32'(div_zero_o), 32'd1);
    tick();

    // Flush at CALC cycle 10, new op at cycle 11.
    sign_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("dz_cleared", 32'(div_zero_o), 32'd0);
    for (int i = 1; i < 10; i++) tick();
    chk("fl_busy_before", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_busy_after", 32'(busy_o), 32'd0);
    chk("fl_valid", 32'(valid_o), 32'd0);
    chk("fl_hold_q", quotient_o, 32'hFFFF_FFFF);
    do_op(1'b0, 32'd50, 32'd5, lat, bcnt);
    chk("fl_new_lat", 32'(lat), 32'd33);
    chk("fl_new_q", quotient_o, 32'd10);
    chk("fl_new_r", remainder_o, 32'd0);
    tick();

    // start_i pulsed at CALC cycle 5 must not disturb the op.
    sign_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd10; start_i = 1'b1;
    tick();
    start_i = 1'b0; lat = 1;
    for (int i = 1; i < 5; i++) begin tick(); lat++; end
    sign_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3; start_i = 1'b1;
    tick(); lat++;
    start_i = 1'b0;
    while (!valid_o && lat < 200) begin tick(); lat++; end
    chk("sb_lat", 32'(lat), 32'd33);
    chk("sb_q", quotient_o, 32'd100);
    chk("sb_r", remainder_o, 32'd0);
    tick();

    // Reset at cycle 20 of a second op.
    sign_i = 1'b0; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_valid", 32'(valid_o), 32'd0);
    chk("mr_q", quotient_o, 32'd0);
    chk("mr_r", remainder_o, 32'd0);
    chk("mr_dz", 32'(div_zero_o), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o || busy_o) vcnt++;
      tick();
    end
    chk("mr_quiet", 32'(vcnt), 32'd0);

    do_op(1'b0, 32'hFFFF_FFFF, 32'd3, lat, bcnt);
    chk("post_q", quotient_o, 32'h5555_5555);
    chk("post_r", remainder_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
